// File: rtl/game_pkg.sv
// Shared types and default constants for the level sequencer.
package game_pkg;

   typedef enum logic [2:0] {
      SPLASH = 3'd0,
      TITLE  = 3'd1,
      BANNER = 3'd2,
      LOAD   = 3'd3,
      PLAY   = 3'd4,
      DEATH  = 3'd5,
      DONE   = 3'd6
   } seq_state_t;

   localparam int         DEF_WAIT_CYCLES = 300;
   localparam logic [2:0] DEF_COIN_MASK   = 3'b110;

   // Width of a level index; a single level still needs one bit.
   function automatic int lidx_width(input int num_levels);
      return (num_levels <= 2) ? 1 : $clog2(num_levels);
   endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Game-side signal bundle: per-level inputs from the play field and the
// state decodes driven back by the sequencer.
interface level_sequencer_if
   import game_pkg::*;
#(
   parameter int NUM_LEVELS = 3,
   parameter int DEATH_W    = 8
);
   localparam int LIDX_W = lidx_width(NUM_LEVELS);

   logic                  Start;
   logic [NUM_LEVELS-1:0] Level_End;
   logic [NUM_LEVELS-1:0] Coin_Collected;
   logic                  Player_Hit;

   seq_state_t            State;
   logic [LIDX_W-1:0]     Level_Idx;
   logic [NUM_LEVELS-1:0] Level_Active;
   logic                  Level_Load;
   logic                  Splash_Active;
   logic                  Title_Active;
   logic                  Banner_Active;
   logic                  Death_Active;
   logic                  Game_Over;
   logic [DEATH_W-1:0]    Deaths;

   // The game logic: drives events, observes the sequencer.
   modport master (
      output Start, Level_End, Coin_Collected, Player_Hit,
      input  State, Level_Idx, Level_Active, Level_Load, Splash_Active,
             Title_Active, Banner_Active, Death_Active, Game_Over, Deaths
   );

   // The sequencer itself.
   modport slave (
      input  Start, Level_End, Coin_Collected, Player_Hit,
      output State, Level_Idx, Level_Active, Level_Load, Splash_Active,
             Title_Active, Banner_Active, Death_Active, Game_Over, Deaths
   );

endinterface

// File: rtl/dwell_timer.sv
// Dwell counter for the timed screens. Counts while enabled and flags the
// last cycle of a WAIT_CYCLES-long dwell; clear restarts it from zero.
module dwell_timer
   import game_pkg::*;
#(
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter int CNT_W       = 16
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic clear,
   input  logic enable,
   output logic done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

   generate
      if (WAIT_CYCLES < 1 || longint'(WAIT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_wait
         $error("dwell_timer: WAIT_CYCLES must be >= 1 and < 2**CNT_W");
      end
   endgenerate

   logic [CNT_W-1:0] cnt;

   // Counter register: clear wins over counting.
   always_ff @(posedge Clk or negedge Reset_n) begin
      // NOTE: sequential state uses non-blocking (<=) so every register
      // samples pre-edge values regardless of block ordering.
      if (!Reset_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign done = enable && (cnt == LAST);

endmodule

// File: rtl/level_sequencer.sv
// Game flow sequencer: splash -> title -> (banner -> load -> play)* -> done,
// with death/retry handling, coin-gated level completion and a saturating
// death counter.
module level_sequencer
   import game_pkg::*;
#(
   parameter int                    NUM_LEVELS  = 3,
   parameter int                    WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter int                    CNT_W       = 16,
   parameter logic [NUM_LEVELS-1:0] COIN_MASK   = NUM_LEVELS'(DEF_COIN_MASK),
   parameter int                    DEATH_W     = 8
) (
   input  logic               Clk,
   input  logic               Reset_n,
   level_sequencer_if.slave   bus
);

   localparam int LIDX_W = lidx_width(NUM_LEVELS);
   localparam logic [LIDX_W-1:0]  LAST_IDX   = LIDX_W'(NUM_LEVELS - 1);
   localparam logic [DEATH_W-1:0] DEATHS_MAX = '1;

   seq_state_t         state, state_next;
   logic [LIDX_W-1:0]  lvl_idx, idx_next;
   logic [DEATH_W-1:0] deaths, deaths_next;

   logic dwell_en;
   logic dwell_clr;
   logic dwell_done;
   logic level_cleared;

   // Only the splash, banner and death screens are timed; the counter
   // restarts whenever the state changes so each entry gets a full dwell.
   assign dwell_en  = (state == SPLASH) || (state == BANNER) || (state == DEATH);
   assign dwell_clr = (state_next != state);

   dwell_timer #(
      .WAIT_CYCLES (WAIT_CYCLES),
      .CNT_W       (CNT_W)
   ) u_dwell (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .clear   (dwell_clr),
      .enable  (dwell_en),
      .done    (dwell_done)
   );

   // A level counts as cleared at its goal only once its coin is held,
   // unless that level does not require a coin.
   assign level_cleared = bus.Level_End[lvl_idx] &&
                          (!COIN_MASK[lvl_idx] || bus.Coin_Collected[lvl_idx]);

   // State, level index and death count registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= SPLASH;
         lvl_idx <= '0;
         deaths  <= '0;
      end else begin
         state   <= state_next;
         lvl_idx <= idx_next;
         deaths  <= deaths_next;
      end
   end

   // Next-state logic; game inputs only matter in PLAY, Start only in
   // TITLE and DONE.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave a variable unassigned and infer a latch.
      state_next  = state;
      idx_next    = lvl_idx;
      deaths_next = deaths;
      unique case (state)
         SPLASH: if (dwell_done) state_next = TITLE;
         TITLE: begin
            if (bus.Start) begin
               state_next  = BANNER;
               idx_next    = '0;
               deaths_next = '0;
            end
         end
         BANNER: if (dwell_done) state_next = LOAD;
         LOAD:   state_next = PLAY;
         PLAY: begin
            if (level_cleared) begin
               if (lvl_idx == LAST_IDX) begin
                  state_next = DONE;
               end else begin
                  state_next = BANNER;
                  idx_next   = lvl_idx + LIDX_W'(1);
               end
            end else if (bus.Player_Hit) begin
               state_next = DEATH;
               if (deaths != DEATHS_MAX) deaths_next = deaths + DEATH_W'(1);
            end
         end
         DEATH: if (dwell_done) state_next = LOAD;
         DONE:  if (bus.Start) state_next = TITLE;
         default: state_next = SPLASH;
      endcase
   end

   // Outputs are pure decodes of the registers: no input reaches them
   // combinationally.
   assign bus.State         = state;
   assign bus.Level_Idx     = lvl_idx;
   assign bus.Deaths        = deaths;
   assign bus.Level_Active  = (state == PLAY) ? (NUM_LEVELS'(1) << lvl_idx) : '0;
   assign bus.Level_Load    = (state == LOAD);
   assign bus.Splash_Active = (state == SPLASH);
   assign bus.Title_Active  = (state == TITLE);
   assign bus.Banner_Active = (state == BANNER);
   assign bus.Death_Active  = (state == DEATH);
   assign bus.Game_Over     = (state == DONE);

endmodule

// File: tb/tb_level_sequencer.sv
// Bench for level_sequencer: directed game scenarios, a screen-level model
// compared on every cycle, plus literal checks on dwell lengths and counts.
module tb_level_sequencer;
   import game_pkg::*;

   localparam int NL        = 3;
   localparam int WAIT      = 4;
   localparam int DW        = 2;
   localparam int DEATH_MAX = (1 << DW) - 1;
   localparam logic [NL-1:0] COIN = 3'b110;

   logic Clk = 1'b0;
   logic Reset_n;
   int   n_checks = 0;
   int   n_errors = 0;

   level_sequencer_if #(.NUM_LEVELS(NL), .DEATH_W(DW)) bus ();

   level_sequencer #(
      .NUM_LEVELS  (NL),
      .WAIT_CYCLES (WAIT),
      .CNT_W       (16),
      .COIN_MASK   (COIN),
      .DEATH_W     (DW)
   ) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- screen-level model ----------------
   seq_state_t m_state;
   int         m_left;
   int         m_idx;
   int         m_deaths;

   task automatic m_enter(input seq_state_t s);
      m_state = s;
      m_left  = WAIT;
   endtask

   task automatic m_dwell(input seq_state_t s);
      if (m_left <= 1) m_enter(s);
      else m_left--;
   endtask

   // Model advances once per clock on the inputs the bench is presenting.
   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         m_enter(SPLASH);
         m_idx    = 0;
         m_deaths = 0;
      end else begin
         case (m_state)
            SPLASH: m_dwell(TITLE);
            TITLE:  if (bus.Start) begin m_enter(BANNER); m_idx = 0; m_deaths = 0; end
            BANNER: m_dwell(LOAD);
            LOAD:   m_enter(PLAY);
            PLAY: begin
               if (bus.Level_End[m_idx] && (!COIN[m_idx] || bus.Coin_Collected[m_idx])) begin
                  if (m_idx == NL - 1) m_enter(DONE);
                  else begin m_idx++; m_enter(BANNER); end
               end else if (bus.Player_Hit) begin
                  m_enter(DEATH);
                  m_deaths = (m_deaths < DEATH_MAX) ? m_deaths + 1 : DEATH_MAX;
               end
            end
            DEATH:  m_dwell(LOAD);
            DONE:   if (bus.Start) m_enter(TITLE);
            default: m_enter(SPLASH);
         endcase
      end
   end

   // Every cycle, shortly after the edge, all outputs must match the model.
   always @(posedge Clk) begin
      #1;
      check("state",   32'(bus.State), 32'(m_state));
      check("idx",     32'(bus.Level_Idx), 32'(m_idx));
      check("deaths",  32'(bus.Deaths), 32'(m_deaths));
      check("active",  32'(bus.Level_Active), (m_state == PLAY) ? (32'd1 << m_idx) : 32'd0);
      check("load",    32'(bus.Level_Load),    32'(m_state == LOAD));
      check("splash",  32'(bus.Splash_Active), 32'(m_state == SPLASH));
      check("title",   32'(bus.Title_Active),  32'(m_state == TITLE));
      check("banner",  32'(bus.Banner_Active), 32'(m_state == BANNER));
      check("death",   32'(bus.Death_Active),  32'(m_state == DEATH));
      check("gameover",32'(bus.Game_Over),     32'(m_state == DONE));
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask

   // Counts consecutive cycles spent in s, starting at the current negedge.
   task automatic measure(input seq_state_t s, output int n);
      n = 0;
      while (bus.State == s && n < 200) begin
         n++;
         @(negedge Clk);
      end
   endtask

   // From the first BANNER cycle, ride through banner and load into PLAY.
   task automatic enter_play(input string tag);
      int n;
      measure(BANNER, n);
      check({tag, "_banner_len"}, n, WAIT);
      check({tag, "_load"}, 32'(bus.Level_Load), 1);
      @(negedge Clk);
      check({tag, "_play"}, 32'(bus.State), 32'(PLAY));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1);
   end

   initial begin
      int n;
      Reset_n            = 1'b0;
      bus.Start          = 1'b0;
      bus.Level_End      = '0;
      bus.Coin_Collected = '0;
      bus.Player_Hit     = 1'b0;

      // Reset values.
      #3;
      check("rst_state",  32'(bus.State), 32'(SPLASH));
      check("rst_splash", 32'(bus.Splash_Active), 1);
      check("rst_title",  32'(bus.Title_Active), 0);
      check("rst_active", 32'(bus.Level_Active), 0);
      check("rst_load",   32'(bus.Level_Load), 0);
      check("rst_idx",    32'(bus.Level_Idx), 0);
      check("rst_deaths", 32'(bus.Deaths), 0);

      cyc(2);
      Reset_n = 1'b1;
      measure(SPLASH, n);
      check("splash_len", n, 4);
      check("title_reached", 32'(bus.Title_Active), 1);

      // Game inputs and idle cycles must not move TITLE.
      bus.Level_End = 3'b111; bus.Coin_Collected = 3'b111; bus.Player_Hit = 1'b1;
      cyc(1);
      bus.Level_End = '0; bus.Coin_Collected = '0; bus.Player_Hit = 1'b0;
      cyc(5);
      check("title_hold", 32'(bus.State), 32'(TITLE));

      // Start -> banner of level 0.
      bus.Start = 1'b1; cyc(1); bus.Start = 1'b0;
      check("l0_banner", 32'(bus.Banner_Active), 1);
      enter_play("l0");
      check("l0_active", 32'(bus.Level_Active), 3'b001);

      // Start and another level's goal are ignored in PLAY.
      bus.Start = 1'b1; bus.Level_End = 3'b010; cyc(1);
      bus.Start = 1'b0; bus.Level_End = '0;
      check("play_ignore", 32'(bus.State), 32'(PLAY));

      // Death and retry at the same level.
      bus.Player_Hit = 1'b1; cyc(1); bus.Player_Hit = 1'b0;
      check("death_cnt1", 32'(bus.Deaths), 1);
      measure(DEATH, n);
      check("death_len", n, 4);
      check("retry_load", 32'(bus.Level_Load), 1);
      check("retry_idx",  32'(bus.Level_Idx), 0);
      cyc(1);
      check("retry_play", 32'(bus.Level_Active), 3'b001);

      // Level 0 needs no coin.
      bus.Level_End = 3'b001; cyc(1); bus.Level_End = '0;
      check("l0_clear_idx", 32'(bus.Level_Idx), 1);
      enter_play("l1");

      // Level 1: goal without coin holds PLAY, coin then completes.
      bus.Level_End = 3'b010; cyc(3);
      check("l1_no_coin", 32'(bus.State), 32'(PLAY));
      bus.Coin_Collected = 3'b010; cyc(1);
      bus.Level_End = '0; bus.Coin_Collected = '0;
      check("l1_clear", 32'(bus.State), 32'(BANNER));
      check("l1_clear_idx", 32'(bus.Level_Idx), 2);
      enter_play("l2");

      // Last level: completion beats a simultaneous hit.
      bus.Level_End = 3'b100; bus.Coin_Collected = 3'b100; bus.Player_Hit = 1'b1;
      cyc(1);
      bus.Level_End = '0; bus.Coin_Collected = '0; bus.Player_Hit = 1'b0;
      check("done_over",   32'(bus.Game_Over), 1);
      check("done_deaths", 32'(bus.Deaths), 1);
      check("done_idx",    32'(bus.Level_Idx), 2);
      bus.Player_Hit = 1'b1; cyc(3); bus.Player_Hit = 1'b0;
      check("done_hold", 32'(bus.State), 32'(DONE));

      bus.Start = 1'b1; cyc(1); bus.Start = 1'b0;
      check("done_title", 32'(bus.State), 32'(TITLE));
      check("title_deaths_kept", 32'(bus.Deaths), 1);
      bus.Start = 1'b1; cyc(1); bus.Start = 1'b0;
      check("new_game_deaths", 32'(bus.Deaths), 0);
      enter_play("g2");

      // Five hits saturate a 2-bit counter at 3.
      for (int k = 0; k < 5; k++) begin
         bus.Player_Hit = 1'b1; cyc(1); bus.Player_Hit = 1'b0;
         measure(DEATH, n);
         cyc(1);
      end
      check("deaths_sat", 32'(bus.Deaths), 3);

      // Clear level 0, then reset in the middle of level 1's banner.
      bus.Level_End = 3'b001; cyc(1); bus.Level_End = '0;
      check("g2_l1_banner", 32'(bus.Level_Idx), 1);
      cyc(1);
      #2 Reset_n = 1'b0;
      #1;
      check("mid_rst_state",  32'(bus.State), 32'(SPLASH));
      check("mid_rst_idx",    32'(bus.Level_Idx), 0);
      check("mid_rst_deaths", 32'(bus.Deaths), 0);
      check("mid_rst_banner", 32'(bus.Banner_Active), 0);
      check("mid_rst_splash", 32'(bus.Splash_Active), 1);
      cyc(2);
      Reset_n = 1'b1;
      measure(SPLASH, n);
      check("splash_len2", n, 4);

      cyc(2);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
